dma_fifo: RTL and testbench
===========================

# dma_fifo

Word-wide first-word-fall-through FIFO that buffers the DMA controller's transfers between the OpenMSP430 memory backbone and the peripheral device. It adds two features for the DMA state machine:
- a partial-empty watermark, so a drained buffer is refilled early;
- a one-step retraction, used when the memory side stalls and the controller re-issues the previous address.

## Interface
Parameters:
- DATA, 16: word width.
- ADDR_SIZE, 5: depth is 2^ADDR_SIZE words (32).
- DIV_FACTOR, 3: watermark is depth >> DIV_FACTOR (4).

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous active-high clear; has the same effect as reset.
- fifo_enable  in  1  performs the selected operation this cycle.
- fifo_wr_rd  in  1  operation select: 1 = write (push), 0 = read (pop).
- fifo_old_add_flag  in  1  retract the last operation in the current direction.
- fifo_in  in  DATA  write data.
- fifo_out  out  DATA  head word (combinational).
- full  out  1  occupancy equals depth.
- empty  out  1  occupancy is 0.
- empty_partial  out  1  occupancy <= depth >> DIV_FACTOR.

## Operation
- State: memory array, rd_ptr and wr_ptr (ADDR_SIZE bits, wrap modulo depth), occupancy count (ADDR_SIZE+1 bits), and a registered copy old_q of fifo_old_add_flag.
- Write: when fifo_enable=1, fifo_wr_rd=1, full=0 and no retraction is active this cycle:
  - mem[wr_ptr] <= fifo_in;
  - wr_ptr +1, count +1.
  - A write while full is ignored; no state change.
- Read: when fifo_enable=1, fifo_wr_rd=0, empty=0 and no retraction is active:
  - rd_ptr +1, count -1.
  - A read while empty is ignored.
- Retraction is active when fifo_old_add_flag=1 and old_q=0 (the first cycle of assertion only). Holding the flag high for further cycles changes nothing.
  - Write mode (fifo_wr_rd=1): wr_ptr -1, count -1, so the last pushed word is discarded. Ignored if count=0.
  - Read mode (fifo_wr_rd=0): rd_ptr -1, count +1, so the last popped word is presented again. Ignored if count=depth.
- Priority: reset > clr > retraction > fifo_enable operation. fifo_enable is a don't-care whenever the flag is high.
- fifo_out = mem[rd_ptr] when empty=0; fifo_out = 0 when empty=1.
- Flags are combinational decodes of count only.
- Memory contents are not reset.

## Timing
- Reset (rst low, or clr high at an edge):
  - pointers, count and old_q are 0;
  - empty=1, full=0, empty_partial=1, fifo_out=0.
- Reset asserted mid-operation drops all buffered data immediately (asynchronously). Operation resumes on the first edge after rst goes high.
- Write latency: a word pushed into an empty FIFO appears on fifo_out right after that clock edge. There is no read latency.
- Pop: the next word appears on fifo_out right after the pop edge. The consumer samples fifo_out in the same cycle it asserts the read.
- Flags update right after the edge that changes count. full asserts after the 32nd write.
- Pointer wrap is transparent: data order is preserved across 31→0.

## Structure
- Shared package holds the op encoding (WR=1, RD=0) and the default DATA, ADDR_SIZE and DIV_FACTOR.
- One sub-module, dma_ptr_counter: an ADDR_SIZE-bit up/down modulo counter with enable and async active-low reset. Instantiated twice (rd_ptr, wr_ptr).
- The count register stays in the top level.

## Test plan
- Reset: hold rst low with data pending, then release. Required: empty=1, full=0, empty_partial=1, fifo_out=0.
- Fill and drain:
  - Write 0x0000..0x001F. full=1 after the 32nd edge.
  - A 33rd write of 0xFFFF is ignored.
  - Reads return 0x0000..0x001F in order, with 0x0000 on fifo_out before the first pop.
  - empty=1 at the end.
- Watermark: start full (32 words).
  - After 27 reads (count 5): empty_partial=0.
  - After the 28th read (count 4): empty_partial=1.
- Write retraction:
  - Push 0xA, 0xB, 0xC, then hold the flag high for 3 cycles with fifo_wr_rd=1 and fifo_enable=1. Required: count=2.
  - Push 0xD. Reads return 0xA, 0xB, 0xD.
- Read retraction:
  - Push 0x11, 0x22 and pop once; fifo_out=0x22.
  - Pulse the flag with fifo_wr_rd=0. Required: fifo_out=0x11, count=2.
- Wrap and mid-operation reset:
  - Write 20 words, read 20, write 20 (0x100..0x113). Required: count=20, full=0, data in order.
  - Then assert rst for one cycle mid-stream. Required: all reset values immediately.

Source files
------------

// File: rtl/dma_fifo_pkg.sv
// rtl/dma_fifo_pkg.sv - shared op encoding and default geometry for the DMA FIFO
package dma_fifo_pkg;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } fifo_op_e;

  localparam int DATA_DEF       = 16;
  localparam int ADDR_SIZE_DEF  = 5;
  localparam int DIV_FACTOR_DEF = 3;

endpackage

// File: rtl/dma_ptr_counter.sv
// rtl/dma_ptr_counter.sv - modulo up/down pointer counter for the DMA FIFO
module dma_ptr_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         up,
  output logic [W-1:0] ptr
);

  // Wrap modulo 2^W falls out of the natural W-bit overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= up ? ptr + W'(1) : ptr - W'(1);
    end
  end

endmodule

// File: rtl/dma_fifo.sv
// rtl/dma_fifo.sv - first-word-fall-through DMA FIFO with watermark and one-step retraction
module dma_fifo
  import dma_fifo_pkg::*;
#(
  parameter int DATA       = DATA_DEF,
  parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
  parameter int DIV_FACTOR = DIV_FACTOR_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            fifo_enable,
  input  logic            fifo_wr_rd,
  input  logic            fifo_old_add_flag,
  input  logic [DATA-1:0] fifo_in,
  output logic [DATA-1:0] fifo_out,
  output logic            full,
  output logic            empty,
  output logic            empty_partial
);

  localparam int                 DEPTH   = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_C = (ADDR_SIZE+1)'(1) << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] WMARK_C = DEPTH_C >> DIV_FACTOR;

  logic [DATA-1:0]      mem [DEPTH];
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE:0]   count;
  logic                 old_q;

  logic retract;
  logic wr_ret;
  logic rd_ret;
  logic do_wr;
  logic do_rd;

  assign empty         = (count == '0);
  assign full          = (count == DEPTH_C);
  assign empty_partial = (count <= WMARK_C);

  // Only the rising edge of the flag retracts; while it is high normal ops are blocked.
  assign retract = fifo_old_add_flag && !old_q;
  assign wr_ret  = retract && (fifo_wr_rd == OP_WR) && !empty;
  assign rd_ret  = retract && (fifo_wr_rd == OP_RD) && !full;
  assign do_wr   = fifo_enable && !fifo_old_add_flag && (fifo_wr_rd == OP_WR) && !full;
  assign do_rd   = fifo_enable && !fifo_old_add_flag && (fifo_wr_rd == OP_RD) && !empty;

  dma_ptr_counter #(.W(ADDR_SIZE)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (do_wr || wr_ret),
    .up  (do_wr),
    .ptr (wr_ptr)
  );

  dma_ptr_counter #(.W(ADDR_SIZE)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (do_rd || rd_ret),
    .up  (do_rd),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      old_q <= 1'b0;
    end else if (clr) begin
      count <= '0;
      old_q <= 1'b0;
    end else begin
      old_q <= fifo_old_add_flag;
      if (do_wr || rd_ret) begin
        count <= count + (ADDR_SIZE+1)'(1);
      end else if (do_rd || wr_ret) begin
        count <= count - (ADDR_SIZE+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) begin
      mem[wr_ptr] <= fifo_in;
    end
  end

  assign fifo_out = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_dma_fifo.sv
// tb/tb_dma_fifo.sv - scoreboard bench for dma_fifo
module tb_dma_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        fifo_enable;
  logic        fifo_wr_rd;
  logic        fifo_old_add_flag;
  logic [15:0] fifo_in;
  logic [15:0] fifo_out;
  logic        full;
  logic        empty;
  logic        empty_partial;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  dma_fifo dut (
    .clk               (clk),
    .rst               (rst),
    .clr               (clr),
    .fifo_enable       (fifo_enable),
    .fifo_wr_rd        (fifo_wr_rd),
    .fifo_old_add_flag (fifo_old_add_flag),
    .fifo_in           (fifo_in),
    .fifo_out          (fifo_out),
    .full              (full),
    .empty             (empty),
    .empty_partial     (empty_partial)
  );

  // Monitor: every issued pop is compared with the head of the expected queue.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst && !clr && fifo_enable && !fifo_wr_rd && !fifo_old_add_flag) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected got=%h required=none", fifo_out);
      end else begin
        e = exp_q.pop_front();
        if (fifo_out !== e) begin
          errors++;
          $display("FAIL pop_data got=%h required=%h", fifo_out, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic chk_flags(input string name, input logic e_empty, input logic e_full,
                           input logic e_part);
    chk({name, "_empty"}, 16'(empty), 16'(e_empty));
    chk({name, "_full"}, 16'(full), 16'(e_full));
    chk({name, "_partial"}, 16'(empty_partial), 16'(e_part));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    fifo_enable       = 1'b0;
    fifo_old_add_flag = 1'b0;
    clr               = 1'b0;
  endtask

  task automatic wr(input logic [15:0] d);
    fifo_enable = 1'b1;
    fifo_wr_rd  = 1'b1;
    fifo_in     = d;
    step();
  endtask

  task automatic rd(input logic [15:0] e);
    exp_q.push_back(e);
    fifo_enable = 1'b1;
    fifo_wr_rd  = 1'b0;
    step();
  endtask

  task automatic retract(input logic dir, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      fifo_old_add_flag = 1'b1;
      fifo_enable       = 1'b1;
      fifo_wr_rd        = dir;
      fifo_in           = 16'hEEEE;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; clr = 1'b0; fifo_enable = 1'b0; fifo_wr_rd = 1'b0;
    fifo_old_add_flag = 1'b0; fifo_in = '0;
    step(); step();
    rst = 1'b1;
    step();

    // Reset with data pending
    wr(16'h1234); wr(16'h5678);
    rst = 1'b0;
    #1;
    chk_flags("reset_async", 1'b1, 1'b0, 1'b1);
    chk("reset_async_out", fifo_out, 16'h0000);
    step();
    rst = 1'b1;
    step();
    chk_flags("reset_release", 1'b1, 1'b0, 1'b1);
    chk("reset_release_out", fifo_out, 16'h0000);

    // Fill and drain
    for (int i = 0; i < 31; i++) wr(16'(i));
    chk_flags("fill31", 1'b0, 1'b0, 1'b0);
    wr(16'd31);
    chk_flags("fill32", 1'b0, 1'b1, 1'b0);
    wr(16'hFFFF);
    chk("overflow_full", 16'(full), 16'd1);
    chk("head_before_pop", fifo_out, 16'h0000);
    for (int i = 0; i < 32; i++) rd(16'(i));
    chk_flags("drained", 1'b1, 1'b0, 1'b1);
    chk("drained_out", fifo_out, 16'h0000);

    // Watermark
    for (int i = 0; i < 32; i++) wr(16'h0200 + 16'(i));
    for (int i = 0; i < 27; i++) rd(16'h0200 + 16'(i));
    chk("wmark_count5", 16'(empty_partial), 16'd0);
    rd(16'h021B);
    chk("wmark_count4", 16'(empty_partial), 16'd1);
    for (int i = 28; i < 32; i++) rd(16'h0200 + 16'(i));
    chk("wmark_empty", 16'(empty), 16'd1);

    // Write retraction, flag held three cycles
    wr(16'h000A); wr(16'h000B); wr(16'h000C);
    retract(1'b1, 3);
    wr(16'h000D);
    rd(16'h000A); rd(16'h000B); rd(16'h000D);
    chk("wret_empty", 16'(empty), 16'd1);

    // Read retraction
    wr(16'h0011); wr(16'h0022);
    rd(16'h0011);
    chk("rret_before", fifo_out, 16'h0022);
    retract(1'b0, 1);
    chk("rret_after", fifo_out, 16'h0011);
    rd(16'h0011); rd(16'h0022);
    chk("rret_empty", 16'(empty), 16'd1);

    // Wrap, then mid-stream reset
    for (int i = 0; i < 20; i++) wr(16'h0300 + 16'(i));
    for (int i = 0; i < 20; i++) rd(16'h0300 + 16'(i));
    for (int i = 0; i < 20; i++) wr(16'h0100 + 16'(i));
    chk_flags("wrap20", 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) rd(16'h0100 + 16'(i));
    #2;
    rst = 1'b0;
    #1;
    chk_flags("midrst", 1'b1, 1'b0, 1'b1);
    chk("midrst_out", fifo_out, 16'h0000);
    step();
    rst = 1'b1;
    step();

    // Synchronous clear behaves like reset
    wr(16'h0777); wr(16'h0888);
    chk("preclr_out", fifo_out, 16'h0777);
    clr = 1'b1;
    step();
    chk_flags("clr", 1'b1, 1'b0, 1'b1);
    chk("clr_out", fifo_out, 16'h0000);
    wr(16'h0999);
    rd(16'h0999);

    step();
    chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
